// File: rtl/panel_pkg.sv
// Shared definitions for the panel key/counter/display path: debouncer FSM
// encoding and default timing for a 50 MHz board clock.
package panel_pkg;

    localparam int unsigned KD_DEBOUNCE_CYCLES = 50000;     // 1 ms
    localparam int unsigned KD_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int unsigned KD_REPEAT_PERIOD   = 5000000;   // 100 ms

    typedef enum logic [2:0] {
        KD_IDLE     = 3'd0,
        KD_DB_PRESS = 3'd1,
        KD_HELD     = 3'd2,
        KD_REPEAT   = 3'd3,
        KD_DB_REL   = 3'd4
    } kd_state_t;

    function automatic int unsigned kd_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pin and debounced event outputs of one panel push-button.
interface key_debounce_if;

    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_repeat;
    logic cnt_pulse;

    // Board/environment side: drives the raw pin, consumes the events.
    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat,
        input  cnt_pulse
    );

    // Debouncer side.
    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat,
        output cnt_pulse
    );

endinterface

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; reset value selects the
// idle level so a released key reads as released straight out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic res,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real stages.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit one-clock press,
// release and auto-repeat pulses, with cnt_pulse feeding the counter stage.
module key_debounce
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KD_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = KD_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = KD_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic           clk,
    input  logic           res,
    key_debounce_if.slave  bus
);

    localparam int unsigned CNT_W =
        $clog2(kd_max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             PIN_IDLE = KEY_ACTIVE_LOW;

    logic             w_key_sync;
    logic             w_k;

    kd_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;
    logic             r_cnt_pulse;

    kd_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_repeat_nxt;

    sync_2ff #(
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clk (clk),
        .res (res),
        .i_d (bus.key_in),
        .o_q (w_key_sync)
    );

    assign w_k = KEY_ACTIVE_LOW ? ~w_key_sync : w_key_sync;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;

        case (r_state)
            KD_IDLE: begin
                if (w_k) begin
                    w_state_nxt = KD_DB_PRESS;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            KD_DB_PRESS: begin
                if (!w_k) begin
                    w_state_nxt = KD_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = KD_HELD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            KD_HELD: begin
                // With repeat disabled the count parks at the delay limit instead of wrapping.
                if (!w_k) begin
                    w_state_nxt = KD_DB_REL;
                    w_cnt_nxt   = CNT_ONE;
                end else if (REPEAT_EN && (r_cnt == RD_LAST)) begin
                    w_state_nxt  = KD_REPEAT;
                    w_cnt_nxt    = '0;
                    w_repeat_nxt = 1'b1;
                end else if (r_cnt != RD_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            KD_REPEAT: begin
                if (!w_k) begin
                    w_state_nxt = KD_DB_REL;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_cnt == RP_LAST) begin
                    w_cnt_nxt    = '0;
                    w_repeat_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            KD_DB_REL: begin
                // A re-press here returns to HELD and restarts the repeat delay silently.
                if (w_k) begin
                    w_state_nxt = KD_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = KD_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = KD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_level_nxt = (w_state_nxt == KD_HELD)   ||
                      (w_state_nxt == KD_REPEAT) ||
                      (w_state_nxt == KD_DB_REL);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state     <= KD_IDLE;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_repeat    <= 1'b0;
            r_cnt_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_level     <= w_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_repeat    <= w_repeat_nxt;
            r_cnt_pulse <= w_press_nxt | w_repeat_nxt;
        end
    end

    assign bus.key_level   = r_level;
    assign bus.key_press   = r_press;
    assign bus.key_release = r_release;
    assign bus.key_repeat  = r_repeat;
    assign bus.cnt_pulse   = r_cnt_pulse;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: two instances (auto-repeat on and off)
// share one key pin; pulse cycles are collected per window and compared.
module tb_key_debounce;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic key_in = 1'b1;

    always #5 clk = ~clk;

    key_debounce_if u_if_rep();
    key_debounce_if u_if_norep();

    assign u_if_rep.key_in   = key_in;
    assign u_if_norep.key_in = key_in;

    key_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .REPEAT_EN       (1'b1),
        .KEY_ACTIVE_LOW  (1'b1)
    ) u_dut_rep (
        .clk (clk),
        .res (res),
        .bus (u_if_rep)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .REPEAT_EN       (1'b0),
        .KEY_ACTIVE_LOW  (1'b1)
    ) u_dut_norep (
        .clk (clk),
        .res (res),
        .bus (u_if_norep)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int n_press, press_cyc, n_rel, rel_cyc, n_rep, n_cntp, level_first, n_level;
    int n_cntp2, n_rep2;
    int rep_cyc[$];
    int n_excl = 0;
    int n_wide = 0;
    int n_cpbad = 0;
    logic prev_press = 1'b0;
    logic prev_rel = 1'b0;
    logic prev_rep = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_press     = 0;
        press_cyc   = -1;
        n_rel       = 0;
        rel_cyc     = -1;
        n_rep       = 0;
        n_cntp      = 0;
        level_first = -1;
        n_level     = 0;
        n_cntp2     = 0;
        n_rep2      = 0;
        rep_cyc.delete();
    endtask

    // One clock: count the edge, then sample outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (u_if_rep.key_press)   begin n_press++; press_cyc = cyc; end
        if (u_if_rep.key_release) begin n_rel++;   rel_cyc   = cyc; end
        if (u_if_rep.key_repeat)  begin n_rep++;   rep_cyc.push_back(cyc); end
        if (u_if_rep.cnt_pulse)   n_cntp++;
        if (u_if_rep.key_level) begin
            n_level++;
            if (level_first < 0) level_first = cyc;
        end
        if (u_if_norep.cnt_pulse)  n_cntp2++;
        if (u_if_norep.key_repeat) n_rep2++;
        if ((int'(u_if_rep.key_press) + int'(u_if_rep.key_release) + int'(u_if_rep.key_repeat)) > 1)
            n_excl++;
        if ((u_if_rep.key_press && prev_press) || (u_if_rep.key_release && prev_rel) ||
            (u_if_rep.key_repeat && prev_rep))
            n_wide++;
        if (u_if_rep.cnt_pulse !== (u_if_rep.key_press | u_if_rep.key_repeat)) n_cpbad++;
        if (u_if_norep.cnt_pulse !== (u_if_norep.key_press | u_if_norep.key_repeat)) n_cpbad++;
        prev_press = u_if_rep.key_press;
        prev_rel   = u_if_rep.key_release;
        prev_rep   = u_if_rep.key_repeat;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},    int'(u_if_rep.key_level),   0);
        check({tag, "_press"},    int'(u_if_rep.key_press),   0);
        check({tag, "_release"},  int'(u_if_rep.key_release), 0);
        check({tag, "_repeat"},   int'(u_if_rep.key_repeat),  0);
        check({tag, "_cntp"},     int'(u_if_rep.cnt_pulse),   0);
        check({tag, "_level_b"},  int'(u_if_norep.key_level), 0);
    endtask

    initial begin
        int t0;
        int t1;

        clear_stats();
        ticks(3);
        check_all_zero("reset");
        res = 1'b1;
        ticks(4);

        // Clean press: pulse and level both appear 6 clocks after the pin edge.
        clear_stats();
        t0 = cyc;
        key_in = 1'b0;
        ticks(10);
        check("s1_press_n",     n_press,     1);
        check("s1_press_cyc",   press_cyc,   t0 + 6);
        check("s1_level_first", level_first, t0 + 6);
        check("s1_repeat_n",    n_rep,       0);

        // Clean release.
        clear_stats();
        t0 = cyc;
        key_in = 1'b1;
        ticks(10);
        check("s4_rel_n",   n_rel,   1);
        check("s4_rel_cyc", rel_cyc, t0 + 6);
        check("s4_press_n", n_press, 0);
        check("s4_level",   int'(u_if_rep.key_level), 0);

        // Release with a 2-cycle re-press glitch while debouncing the release.
        key_in = 1'b0;
        ticks(10);
        clear_stats();
        t0 = cyc;
        key_in = 1'b1;
        ticks(2);
        key_in = 1'b0;
        ticks(2);
        key_in = 1'b1;
        t1 = cyc;
        ticks(10);
        check("s4g_press_n", n_press, 0);
        check("s4g_rel_n",   n_rel,   1);
        check("s4g_rel_cyc", rel_cyc, t1 + 6);
        check("s4g_level_n", n_level, 9);

        // Bounce: 2 cycles pressed, 2 released, for 20 cycles.
        ticks(4);
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            key_in = 1'b0;
            ticks(2);
            key_in = 1'b1;
            ticks(2);
        end
        ticks(10);
        check("s2_press_n", n_press, 0);
        check("s2_cntp_n",  n_cntp,  0);
        check("s2_level_n", n_level, 0);
        check("s2_rel_n",   n_rel,   0);

        // 60-cycle hold on both instances.
        clear_stats();
        t0 = cyc;
        key_in = 1'b0;
        ticks(60);
        key_in = 1'b1;
        ticks(12);
        check("s3_press_n",   n_press,   1);
        check("s3_press_cyc", press_cyc, t0 + 6);
        check("s3_repeat_n",  n_rep,     5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s3_repeat%0d_cyc", i),
                  (i < rep_cyc.size()) ? rep_cyc[i] : -1, t0 + 26 + 8 * i);
        end
        check("s3_cntp_n",    n_cntp,  6);
        check("s3_rel_n",     n_rel,   1);
        check("s3_rel_cyc",   rel_cyc, t0 + 66);
        check("s6_cntp_n",    n_cntp2, 1);
        check("s6_repeat_n",  n_rep2,  0);

        // Reset while auto-repeating, key kept pressed through and after reset.
        ticks(4);
        clear_stats();
        key_in = 1'b0;
        ticks(30);
        check("s5_pre_level",    int'(u_if_rep.key_level), 1);
        check("s5_pre_repeat_n", n_rep, 1);
        #1;
        res = 1'b0;
        #1;
        check_all_zero("s5_async");
        ticks(3);
        check("s5_rst_rel_n", n_rel, 0);
        clear_stats();
        t0 = cyc;
        res = 1'b1;
        ticks(10);
        check("s5_press_n",   n_press,   1);
        check("s5_press_cyc", press_cyc, t0 + 6);
        check("s5_rel_n",     n_rel,     0);
        key_in = 1'b1;
        ticks(10);

        check("excl_pulses",  n_excl,  0);
        check("wide_pulses",  n_wide,  0);
        check("cntp_formula", n_cpbad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
